video_mnist_class_vote: RTL

- Producer side of the MNIST colour stream: turns raw per-pixel binary-network class outputs into the tnumber/tcount sideband that the colour stage consumes.
- Each pixel arrives with NUM_CLASS groups of CLASS_DUP replicated class bits. The block popcounts each group and selects the winning class (argmax).
- Emits winner index and vote count alongside the pixel's tdata/tuser/tlast on an AXI4-Stream master.
- Sits between the binary-network LUT output and the colour stage, in the aclk domain.

---
 rtl/video_mnist_class_vote.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/video_mnist_class_vote.sv
// video_mnist_class_vote: counts the replicated voter bits of every class, picks the
// winning class (lowest index on ties) and emits index/count with the pixel sideband.
module video_mnist_class_vote #(
  parameter int unsigned TUSER_WIDTH   = 1,
  parameter int unsigned TDATA_WIDTH   = 32,
  parameter int unsigned NUM_CLASS     = 10,
  parameter int unsigned CLASS_DUP     = 7,
  parameter int unsigned TNUMBER_WIDTH = 4,
  parameter int unsigned TCOUNT_WIDTH  = 4
) (
  input  logic                           aresetn,
  input  logic                           aclk,
  input  logic [TUSER_WIDTH-1:0]         s_axi4s_tuser,
  input  logic                           s_axi4s_tlast,
  input  logic [TDATA_WIDTH-1:0]         s_axi4s_tdata,
  input  logic [NUM_CLASS*CLASS_DUP-1:0] s_axi4s_tclass,
  input  logic                           s_axi4s_tvalid,
  output logic                           s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]         m_axi4s_tuser,
  output logic                           m_axi4s_tlast,
  output logic [TNUMBER_WIDTH-1:0]       m_axi4s_tnumber,
  output logic [TCOUNT_WIDTH-1:0]        m_axi4s_tcount,
  output logic [TDATA_WIDTH-1:0]         m_axi4s_tdata,
  output logic                           m_axi4s_tvalid,
  input  logic                           m_axi4s_tready
);

  localparam int unsigned HALF = NUM_CLASS / 2;

  logic cke;

  // Stage 1 registers: sideband plus per-class vote counts
  logic                     s1_valid_q;
  logic [TUSER_WIDTH-1:0]   s1_user_q;
  logic                     s1_last_q;
  logic [TDATA_WIDTH-1:0]   s1_data_q;
  logic [TCOUNT_WIDTH-1:0]  s1_cnt_q [NUM_CLASS];
  logic [TCOUNT_WIDTH-1:0]  s1_cnt_d [NUM_CLASS];

  // Stage 2 registers: per-half winners plus sideband
  logic                     s2_valid_q;
  logic [TUSER_WIDTH-1:0]   s2_user_q;
  logic                     s2_last_q;
  logic [TDATA_WIDTH-1:0]   s2_data_q;
  logic [TNUMBER_WIDTH-1:0] s2_lo_idx_q, s2_lo_idx_d;
  logic [TCOUNT_WIDTH-1:0]  s2_lo_cnt_q, s2_lo_cnt_d;
  logic [TNUMBER_WIDTH-1:0] s2_hi_idx_q, s2_hi_idx_d;
  logic [TCOUNT_WIDTH-1:0]  s2_hi_cnt_q, s2_hi_cnt_d;

  // Stage 3 combine result
  logic [TNUMBER_WIDTH-1:0] s3_idx_d;
  logic [TCOUNT_WIDTH-1:0]  s3_cnt_d;

  // Whole pipeline moves together; an empty output register never blocks
  assign cke            = !m_axi4s_tvalid || m_axi4s_tready;
  assign s_axi4s_tready = cke;

  // Popcount of each class group
  always_comb begin
    for (int unsigned c = 0; c < NUM_CLASS; c++) begin
      s1_cnt_d[c] = '0;
      for (int unsigned b = 0; b < CLASS_DUP; b++) begin
        s1_cnt_d[c] = s1_cnt_d[c] + TCOUNT_WIDTH'(s_axi4s_tclass[c*CLASS_DUP + b]);
      end
    end
  end

  // Argmax within each half; strict compare keeps the lower index on ties
  always_comb begin
    s2_lo_idx_d = '0;
    s2_lo_cnt_d = s1_cnt_q[0];
    for (int unsigned c = 1; c < HALF; c++) begin
      if (s1_cnt_q[c] > s2_lo_cnt_d) begin
        s2_lo_idx_d = TNUMBER_WIDTH'(c);
        s2_lo_cnt_d = s1_cnt_q[c];
      end
    end
    s2_hi_idx_d = TNUMBER_WIDTH'(HALF);
    s2_hi_cnt_d = s1_cnt_q[HALF];
    for (int unsigned c = HALF + 1; c < NUM_CLASS; c++) begin
      if (s1_cnt_q[c] > s2_hi_cnt_d) begin
        s2_hi_idx_d = TNUMBER_WIDTH'(c);
        s2_hi_cnt_d = s1_cnt_q[c];
      end
    end
  end

  // Upper half wins only with a strictly larger count
  always_comb begin
    s3_idx_d = s2_lo_idx_q;
    s3_cnt_d = s2_lo_cnt_q;
    if (s2_hi_cnt_q > s2_lo_cnt_q) begin
      s3_idx_d = s2_hi_idx_q;
      s3_cnt_d = s2_hi_cnt_q;
    end
  end

  // Stage 1: capture input beat and counts
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid_q <= 1'b0;
      s1_user_q  <= '0;
      s1_last_q  <= 1'b0;
      s1_data_q  <= '0;
      for (int unsigned c = 0; c < NUM_CLASS; c++) s1_cnt_q[c] <= '0;
    end else if (cke) begin
      s1_valid_q <= s_axi4s_tvalid;
      s1_user_q  <= s_axi4s_tuser;
      s1_last_q  <= s_axi4s_tlast;
      s1_data_q  <= s_axi4s_tdata;
      for (int unsigned c = 0; c < NUM_CLASS; c++) s1_cnt_q[c] <= s1_cnt_d[c];
    end
  end

  // Stage 2: capture per-half winners
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s2_valid_q  <= 1'b0;
      s2_user_q   <= '0;
      s2_last_q   <= 1'b0;
      s2_data_q   <= '0;
      s2_lo_idx_q <= '0;
      s2_lo_cnt_q <= '0;
      s2_hi_idx_q <= '0;
      s2_hi_cnt_q <= '0;
    end else if (cke) begin
      s2_valid_q  <= s1_valid_q;
      s2_user_q   <= s1_user_q;
      s2_last_q   <= s1_last_q;
      s2_data_q   <= s1_data_q;
      s2_lo_idx_q <= s2_lo_idx_d;
      s2_lo_cnt_q <= s2_lo_cnt_d;
      s2_hi_idx_q <= s2_hi_idx_d;
      s2_hi_cnt_q <= s2_hi_cnt_d;
    end
  end

  // Stage 3: output register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axi4s_tvalid  <= 1'b0;
      m_axi4s_tuser   <= '0;
      m_axi4s_tlast   <= 1'b0;
      m_axi4s_tdata   <= '0;
      m_axi4s_tnumber <= '0;
      m_axi4s_tcount  <= '0;
    end else if (cke) begin
      m_axi4s_tvalid  <= s2_valid_q;
      m_axi4s_tuser   <= s2_user_q;
      m_axi4s_tlast   <= s2_last_q;
      m_axi4s_tdata   <= s2_data_q;
      m_axi4s_tnumber <= s3_idx_d;
      m_axi4s_tcount  <= s3_cnt_d;
    end
  end

endmodule
